pkt_disposition: RTL and testbench

//  End-of-pipeline consumer of the per-packet metadata written by the action ALUs.

---
 rtl/rmt_meta_pkg.sv | 27 ++
 rtl/meta_fifo.sv | 48 ++++
 rtl/pkt_disposition.sv | 139 +++++++++++++
 tb/tb_pkt_disposition.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_meta_pkg.sv
// Shared metadata layout and disposition FSM encodings for the RMT output stage.
package rmt_meta_pkg;

    // Metadata word field positions
    localparam int unsigned META_LEN_DEF      = 256;
    localparam int unsigned META_NTID_MSB     = 255;
    localparam int unsigned META_NTID_LSB     = 250;
    localparam int unsigned META_DISCARD_BIT  = 128;
    localparam int unsigned META_MD_MSB       = 127;
    localparam int unsigned META_DST_PORT_MSB = 31;
    localparam int unsigned META_DST_PORT_LSB = 24;

    // Queue entry stores {discard, md}
    localparam int unsigned META_FIFO_W = META_MD_MSB + 2;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        FWD_S  = 2'd1,
        DROP_S = 2'd2
    } state_e;

    // Destination port field of a NetFPGA md slice
    function automatic logic [7:0] md_dst_port(input logic [META_MD_MSB:0] md);
        return md[META_DST_PORT_MSB:META_DST_PORT_LSB];
    endfunction

endpackage

// File: rtl/meta_fifo.sv
// Synchronous FIFO holding {discard, md} entries awaiting their packet.
module meta_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; wraps naturally at power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/pkt_disposition.sv
// Pairs each metadata word with one packet: forwards it with rewritten tuser or drops it.
module pkt_disposition
    import rmt_meta_pkg::*;
#(
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned TUSER_W         = 128,
    parameter int unsigned META_LEN        = 256,
    parameter int unsigned META_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [META_LEN-1:0]   meta_in,
    input  logic                  meta_valid_in,
    output logic                  meta_ready_out,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic [TUSER_W-1:0]    s_axis_tuser,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic [TUSER_W-1:0]    m_axis_tuser,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           fwd_pkt_cnt,
    output logic [31:0]           drop_pkt_cnt
);

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [META_FIFO_W-1:0] w_fifo_din;
    logic [META_FIFO_W-1:0] w_head;
    logic                   w_meta_unused;

    state_e                 r_state;
    logic                   r_rst_done;
    logic                   r_first;
    logic [TUSER_W-1:0]     r_md;
    logic [31:0]            r_fwd_cnt;
    logic [31:0]            r_drop_cnt;

    // next_table_id and reserved bits are not consumed here
    assign w_meta_unused = ^{meta_in[META_NTID_MSB:META_NTID_LSB],
                             meta_in[META_NTID_LSB-1:META_DISCARD_BIT+1]};

    assign w_fifo_din     = {meta_in[META_DISCARD_BIT], meta_in[META_MD_MSB:0]};
    // Held low while in reset and for the first edge after release
    assign meta_ready_out = r_rst_done && !w_fifo_full;
    assign w_push         = meta_valid_in && meta_ready_out;
    // Packet starts only once its metadata is at the head of the queue
    assign w_pop          = (r_state == IDLE_S) && !w_fifo_empty && s_axis_tvalid;

    meta_fifo #(
        .WIDTH (META_FIFO_W),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Disposition FSM, first-beat flag and packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE_S;
            r_rst_done <= 1'b0;
            r_first    <= 1'b0;
            r_md       <= '0;
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rst_done <= 1'b1;
            case (r_state)
                IDLE_S: begin
                    if (w_pop) begin
                        r_md    <= w_head[TUSER_W-1:0];
                        r_first <= 1'b1;
                        r_state <= w_head[META_DISCARD_BIT] ? DROP_S : FWD_S;
                    end
                end
                FWD_S: begin
                    if (s_axis_tvalid && m_axis_tready) begin
                        r_first <= 1'b0;
                        if (s_axis_tlast) begin
                            r_fwd_cnt <= r_fwd_cnt + 32'd1;
                            r_state   <= IDLE_S;
                        end
                    end
                end
                DROP_S: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                        r_state    <= IDLE_S;
                    end
                end
                default: r_state <= IDLE_S;
            endcase
        end
    end

    // Stream steering: pass-through in FWD_S, sink in DROP_S, quiet otherwise
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        case (r_state)
            FWD_S: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = r_first ? r_md : s_axis_tuser;
            end
            DROP_S: begin
                s_axis_tready = 1'b1;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    assign fwd_pkt_cnt  = r_fwd_cnt;
    assign drop_pkt_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pkt_disposition.sv
// Directed bench for pkt_disposition: forward, drop, ordering, queue-full and reset cases.
module tb_pkt_disposition;

    localparam int unsigned DATA_W   = 512;
    localparam int unsigned TUSER_W  = 128;
    localparam int unsigned META_LEN = 256;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned KEEP_W   = DATA_W / 8;

    logic                clk;
    logic                rst_n;
    logic [META_LEN-1:0] meta_in;
    logic                meta_valid_in;
    logic                meta_ready_out;
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [KEEP_W-1:0]   s_axis_tkeep;
    logic [TUSER_W-1:0]  s_axis_tuser;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                s_axis_tready;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [KEEP_W-1:0]   m_axis_tkeep;
    logic [TUSER_W-1:0]  m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tready;
    logic [31:0]         fwd_pkt_cnt;
    logic [31:0]         drop_pkt_cnt;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0]  obs_data [$];
    logic [KEEP_W-1:0]  obs_keep [$];
    logic [TUSER_W-1:0] obs_user [$];
    logic               obs_last [$];

    pkt_disposition #(
        .DATA_W          (DATA_W),
        .TUSER_W         (TUSER_W),
        .META_LEN        (META_LEN),
        .META_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .meta_in        (meta_in),
        .meta_valid_in  (meta_valid_in),
        .meta_ready_out (meta_ready_out),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .fwd_pkt_cnt    (fwd_pkt_cnt),
        .drop_pkt_cnt   (drop_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] beat_data(input int k);
        logic [31:0] w;
        w = (32'(k) * 32'h01010101) ^ 32'hA5A50000;
        return {16{w}};
    endfunction

    function automatic logic [KEEP_W-1:0] beat_keep(input int k);
        logic [KEEP_W-1:0] all_ones;
        all_ones = '1;
        return all_ones >> (k % 8);
    endfunction

    function automatic logic [TUSER_W-1:0] beat_user(input int k);
        logic [31:0] w;
        w = 32'h50000000 + 32'(k);
        return {4{w}};
    endfunction

    function automatic logic [127:0] make_md(input logic [7:0] dst, input logic [7:0] tag);
        return {88'h0123456789ABCDEF012345, tag, dst, 24'h00BEEF};
    endfunction

    task automatic clear_obs();
        obs_data.delete();
        obs_keep.delete();
        obs_user.delete();
        obs_last.delete();
    endtask

    task automatic drive_beat(input int k, input logic last);
        s_axis_tdata  = beat_data(k);
        s_axis_tkeep  = beat_keep(k);
        s_axis_tuser  = beat_user(k);
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
    endtask

    // Offer one metadata word and hold it until accepted
    task automatic push_meta(input logic disc, input logic [7:0] dst, input logic [7:0] tag);
        bit got;
        got = 0;
        meta_in = '0;
        meta_in[127:0] = make_md(dst, tag);
        meta_in[128] = disc;
        meta_in[255:250] = 6'h2A;
        meta_valid_in = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (meta_ready_out) got = 1;
            @(posedge clk);
            #1;
        end
        meta_valid_in = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL push_meta_timeout: meta_ready_out stayed 0, required 1 within 50 cycles");
        end
    endtask

    // Send n beats starting at pattern index base; record output handshakes
    task automatic xfer_pkt(input int n, input int base, input bit with_last, input bit rnd,
                            output int cycles);
        bit done;
        bit aborted;
        cycles  = 0;
        aborted = 0;
        for (int b = 0; b < n && !aborted; b++) begin
            drive_beat(base + b, with_last && (b == n - 1));
            done = 0;
            for (int c = 0; c < 200 && !done; c++) begin
                if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (s_axis_tready) begin
                    done = 1;
                    if (m_axis_tvalid && m_axis_tready) begin
                        obs_data.push_back(m_axis_tdata);
                        obs_keep.push_back(m_axis_tkeep);
                        obs_user.push_back(m_axis_tuser);
                        obs_last.push_back(m_axis_tlast);
                    end
                end
                @(posedge clk);
                #1;
                cycles++;
            end
            if (!done) begin
                aborted = 1;
                vectors++;
                miscompares++;
                $display("FAIL xfer_timeout: beat %0d s_axis_tready stayed 0, required 1", b);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        vectors++;
        if (meta_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_meta_ready: got %b want 0", meta_ready_out);
        end
        vectors++;
        if (s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_s_tready: got %b want 0", s_axis_tready);
        end
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_m_valid: got %b/%b want 0/0", m_axis_tvalid, m_axis_tlast);
        end
        vectors++;
        if (m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0) begin
            miscompares++;
            $display("FAIL reset_m_data: got nonzero data/user/keep, want 0");
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", fwd_pkt_cnt, drop_pkt_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_meta_ready: got %b want 1", meta_ready_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fwd();
        int cyc;
        clear_obs();
        push_meta(1'b0, 8'h04, 8'h01);
        xfer_pkt(3, 10, 1'b1, 1'b0, cyc);
        vectors++;
        if (obs_data.size() != 3) begin
            miscompares++;
            $display("FAIL fwd_beats: got %0d want 3", obs_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_data[i] !== beat_data(10 + i) || obs_keep[i] !== beat_keep(10 + i) ||
                    obs_last[i] !== (i == 2)) begin
                    miscompares++;
                    $display("FAIL fwd_beat%0d_data: got last=%b keep=%h want last=%b keep=%h",
                             i, obs_last[i], obs_keep[i], (i == 2), beat_keep(10 + i));
                end
                vectors++;
                if (obs_user[i] !== ((i == 0) ? make_md(8'h04, 8'h01) : beat_user(10 + i))) begin
                    miscompares++;
                    $display("FAIL fwd_beat%0d_user: got %h", i, obs_user[i]);
                end
            end
            vectors++;
            if (obs_user[0][31:24] !== 8'h04) begin
                miscompares++;
                $display("FAIL fwd_dst_port: got %h want 04", obs_user[0][31:24]);
            end
        end
        vectors++;
        if (cyc != 4) begin
            miscompares++;
            $display("FAIL fwd_cycles: got %0d want 4", cyc);
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd1 || drop_pkt_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL fwd_counters: got %0d/%0d want 1/0", fwd_pkt_cnt, drop_pkt_cnt);
        end
    endtask

    task automatic test_drop();
        int cyc;
        clear_obs();
        push_meta(1'b1, 8'h07, 8'h02);
        xfer_pkt(5, 20, 1'b1, 1'b0, cyc);
        vectors++;
        if (obs_data.size() != 0) begin
            miscompares++;
            $display("FAIL drop_output: got %0d beats want 0", obs_data.size());
        end
        vectors++;
        if (cyc != 6) begin
            miscompares++;
            $display("FAIL drop_cycles: got %0d want 6", cyc);
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd1 || drop_pkt_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL drop_counters: got %0d/%0d want 1/1", fwd_pkt_cnt, drop_pkt_cnt);
        end
    endtask

    task automatic test_meta_late();
        int cyc;
        int bad;
        clear_obs();
        bad = 0;
        drive_beat(30, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL late_meta_stall: got %0d cycles with tready/tvalid set, want 0", bad);
        end
        push_meta(1'b0, 8'h09, 8'h03);
        xfer_pkt(2, 30, 1'b1, 1'b0, cyc);
        vectors++;
        if (obs_data.size() != 2) begin
            miscompares++;
            $display("FAIL late_beats: got %0d want 2", obs_data.size());
        end else begin
            vectors++;
            if (obs_user[0] !== make_md(8'h09, 8'h03) || obs_data[1] !== beat_data(31) ||
                obs_user[1] !== beat_user(31)) begin
                miscompares++;
                $display("FAIL late_content: got user0=%h", obs_user[0]);
            end
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL late_fwd_cnt: got %0d want 2", fwd_pkt_cnt);
        end
    endtask

    task automatic test_full();
        int cyc;
        for (int i = 0; i < 4; i++) push_meta(1'b0, 8'(8'h10 + i), 8'(8'h10 + i));
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got %b want 0", meta_ready_out);
        end
        @(posedge clk);
        #1;
        clear_obs();
        meta_in = '0;
        meta_in[127:0] = make_md(8'h14, 8'h14);
        meta_valid_in = 1'b1;
        drive_beat(40, 1'b1);
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b0 || s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_bubble: got ready=%b tready=%b want 0/0",
                     meta_ready_out, s_axis_tready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b1 || s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after_pop: got ready=%b tready=%b tvalid=%b want 1/1/1",
                     meta_ready_out, s_axis_tready, m_axis_tvalid);
        end
        vectors++;
        if (m_axis_tuser !== make_md(8'h10, 8'h10)) begin
            miscompares++;
            $display("FAIL full_head_md: got %h", m_axis_tuser);
        end
        @(posedge clk);
        #1;
        meta_valid_in = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_refill: got ready=%b want 0", meta_ready_out);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            clear_obs();
            xfer_pkt(1, 41 + i, 1'b1, 1'b0, cyc);
            vectors++;
            if (obs_user.size() != 1 || obs_user[0] !== make_md(8'(8'h11 + i), 8'(8'h11 + i))) begin
                miscompares++;
                $display("FAIL full_drain%0d: got %0d beats, want 1 with dst %h",
                         i, obs_user.size(), 8'h11 + i);
            end
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd7) begin
            miscompares++;
            $display("FAIL full_fwd_cnt: got %0d want 7", fwd_pkt_cnt);
        end
    endtask

    task automatic test_alternate();
        int cyc;
        logic [DATA_W-1:0]  exp_data [$];
        logic [TUSER_W-1:0] exp_user [$];
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            push_meta(1'(i % 2), 8'(8'h20 + i), 8'(i));
            if (i % 2 == 0) begin
                exp_data.push_back(beat_data(60 + i));
                exp_user.push_back(make_md(8'(8'h20 + i), 8'(i)));
            end
            xfer_pkt(1, 60 + i, 1'b1, 1'b1, cyc);
        end
        vectors++;
        if (obs_data.size() != exp_data.size()) begin
            miscompares++;
            $display("FAIL alt_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                vectors++;
                if (obs_data[i] !== exp_data[i] || obs_user[i] !== exp_user[i] ||
                    obs_last[i] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL alt_pkt%0d: got user %h want %h", i, obs_user[i], exp_user[i]);
                end
            end
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd11 || drop_pkt_cnt !== 32'd5) begin
            miscompares++;
            $display("FAIL alt_counters: got %0d/%0d want 11/5", fwd_pkt_cnt, drop_pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        clear_obs();
        push_meta(1'b0, 8'h30, 8'h30);
        push_meta(1'b0, 8'h31, 8'h31);
        xfer_pkt(2, 80, 1'b0, 1'b0, cyc);
        drive_beat(82, 1'b0);
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_reset: got tvalid=%b want 1", m_axis_tvalid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got tvalid=%b tready=%b want 0/0",
                     m_axis_tvalid, s_axis_tready);
        end
        vectors++;
        if (fwd_pkt_cnt !== 32'd0 || drop_pkt_cnt !== 32'd0 || meta_ready_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got cnt %0d/%0d ready=%b want 0/0/0",
                     fwd_pkt_cnt, drop_pkt_cnt, meta_ready_out);
        end
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (meta_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release_ready: got %b want 1", meta_ready_out);
        end
        @(posedge clk);
        #1;
        bad = 0;
        drive_beat(90, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_queue_empty: got %0d cycles accepting without metadata, want 0",
                     bad);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        meta_in       = '0;
        meta_valid_in = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_fwd();
        test_drop();
        test_meta_late();
        test_full();
        test_alternate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
